// File: rtl/data_memory_arbiter_if.sv
// Request/response bus between the two data-memory requesters and the arbiter.
// Port 0 is the CPU load/store path, port 1 the loader/debug path.
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_write;
    logic [1:0]            req_lock;
    logic [DATA_WIDTH-1:0] req_addr0;
    logic [DATA_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [1:0]            resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata0;
    logic [DATA_WIDTH-1:0] resp_rdata1;

    // Requester side
    modport master (
        output req_valid, req_write, req_lock,
        output req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, resp_valid, resp_rdata0, resp_rdata1
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_lock,
        input  req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, resp_valid, resp_rdata0, resp_rdata1
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Round-robin with a bounded burst lock; grant and memory drive are
// combinational, each port gets a registered response one cycle later.
module data_memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_arbiter_if.slave  bus,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    logic          last_grant, last_grant_nxt;
    logic          owner, owner_nxt;
    logic [BW-1:0] burst_count, burst_nxt;
    logic          gnt_vld, gnt_port;

    // Arbitration: single requester wins; on a tie the locked owner keeps the
    // grant until its burst budget is spent, otherwise alternate.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        case (bus.req_valid)
            2'b01: gnt_vld = 1'b1;
            2'b10: begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b1;
            end
            2'b11: begin
                gnt_vld = 1'b1;
                if (bus.req_lock[owner] && (burst_count < BURST_MAX))
                    gnt_port = owner;
                else
                    gnt_port = ~last_grant;
            end
            default: ;
        endcase
    end

    // Arbitration state register; last_grant resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            burst_count <= '0;
        end else begin
            last_grant  <= last_grant_nxt;
            owner       <= owner_nxt;
            burst_count <= burst_nxt;
        end
    end

    // Next state: count consecutive grants to the owner, restart on a new owner,
    // and drop to zero on any idle cycle so a lock never survives a gap.
    always_comb begin
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        burst_nxt      = '0;
        if (gnt_vld) begin
            last_grant_nxt = gnt_port;
            if ((gnt_port == owner) && (burst_count != '0)) begin
                burst_nxt = (burst_count == BURST_MAX) ? BURST_MAX : burst_count + BURST_ONE;
            end else begin
                owner_nxt = gnt_port;
                burst_nxt = BURST_ONE;
            end
        end
    end

    // Outputs: ready and write enable are forced low while reset is high so an
    // asynchronous reset aborts an in-flight store immediately.
    always_comb begin
        bus.req_ready    = {gnt_port, ~gnt_port} & {2{gnt_vld & ~reset}};
        mem_address      = (gnt_vld && gnt_port) ? bus.req_addr1  : bus.req_addr0;
        mem_data_in      = (gnt_vld && gnt_port) ? bus.req_wdata1 : bus.req_wdata0;
        mem_write_enable = gnt_vld && !reset && bus.req_write[gnt_port];
    end

    // Response: capture the pre-edge read word for whichever port was accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.resp_valid  <= 2'b00;
            bus.resp_rdata0 <= '0;
            bus.resp_rdata1 <= '0;
        end else begin
            bus.resp_valid <= bus.req_ready;
            if (bus.req_ready[0]) bus.resp_rdata0 <= mem_data_out;
            if (bus.req_ready[1]) bus.resp_rdata1 <= mem_data_out;
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small word memory model.
module tb_data_memory_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_load;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_write_enable;
    logic [31:0] mem [16];
    int          checks = 0;
    int          failures = 0;

    data_memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

    data_memory_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, store on the rising edge, word i preloaded to i
    assign mem_data_out = mem[mem_address[5:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= i;
        end else if (mem_write_enable) begin
            mem[mem_address[5:2]] <= mem_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_lock   = l;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_wdata0 = d0;
        bus.req_wdata1 = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pat [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        reset    = 1'b1;
        mem_load = 1'b1;
        drive(2'b11, 2'b11, 2'b00, 32'h0, 32'h4, 32'hFFFF_FFFF);
        #2;
        chk("rst_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_write_enable}, 32'd0);
        chk("rst_resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("rst_rdata0", bus.resp_rdata0, 32'd0);
        chk("rst_rdata1", bus.resp_rdata1, 32'd0);
        repeat (2) tick();
        mem_load = 1'b0;
        reset    = 1'b0;
        chk("rst_mem0_kept", mem[0], 32'd0);

        // Both ports loading, no lock: strict alternation starting with port 0
        drive(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", {30'b0, bus.req_ready}, (i % 2) ? 32'd2 : 32'd1);
            chk("rr_addr", mem_address, (i % 2) ? 32'h4 : 32'h0);
            tick();
            chk("rr_resp_valid", {30'b0, bus.resp_valid}, (i % 2) ? 32'd2 : 32'd1);
            chk("rr_rdata", (i % 2) ? bus.resp_rdata1 : bus.resp_rdata0, (i % 2) ? 32'd1 : 32'd0);
        end

        // Store then load of the same address on port 0
        drive(2'b01, 2'b01, 2'b00, 32'h8, 32'h0, 32'hDEAD_BEEF);
        #1;
        chk("st_ready", {30'b0, bus.req_ready}, 32'd1);
        chk("st_we", {31'b0, mem_write_enable}, 32'd1);
        chk("st_addr", mem_address, 32'h8);
        chk("st_wdata", mem_data_in, 32'hDEAD_BEEF);
        tick();
        chk("st_resp_valid", {30'b0, bus.resp_valid}, 32'd1);
        chk("st_old_word", bus.resp_rdata0, 32'd2);
        drive(2'b01, 2'b00, 2'b00, 32'h8, 32'h0, 32'h0);
        #1;
        chk("ld_we", {31'b0, mem_write_enable}, 32'd0);
        tick();
        chk("ld_new_word", bus.resp_rdata0, 32'hDEAD_BEEF);
        chk("rdata1_hold", bus.resp_rdata1, 32'd1);

        // Idle cycle: no grant, no write even with write asserted, port 0 address on the bus
        drive(2'b00, 2'b01, 2'b00, 32'h8, 32'h0, 32'h0);
        #1;
        chk("idle_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("idle_we", {31'b0, mem_write_enable}, 32'd0);
        chk("idle_addr", mem_address, 32'h8);
        tick();
        chk("idle_resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("idle_rdata0_hold", bus.resp_rdata0, 32'hDEAD_BEEF);

        // Port 1 locked, both valid: 4 grants to 1, forced yield to 0, lock re-won
        drive(2'b11, 2'b00, 2'b10, 32'h0, 32'hC, 32'h0);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("burst_ready", {30'b0, bus.req_ready}, pat[i] ? 32'd2 : 32'd1);
            tick();
            chk("burst_resp_valid", {30'b0, bus.resp_valid}, pat[i] ? 32'd2 : 32'd1);
            chk("burst_rdata", pat[i] ? bus.resp_rdata1 : bus.resp_rdata0, pat[i] ? 32'd3 : 32'd0);
        end

        // Budget exhausted, then an idle cycle clears it: lock wins the next tie again
        drive(2'b00, 2'b00, 2'b10, 32'h0, 32'hC, 32'h0);
        #1;
        chk("gap_ready", {30'b0, bus.req_ready}, 32'd0);
        tick();
        drive(2'b11, 2'b00, 2'b10, 32'h0, 32'hC, 32'h0);
        #1;
        chk("relock_ready", {30'b0, bus.req_ready}, 32'd2);
        tick();
        // Port 1 idles one cycle, then round-robin picks the port other than last grant
        drive(2'b01, 2'b00, 2'b10, 32'h0, 32'hC, 32'h0);
        #1;
        chk("p1idle_ready", {30'b0, bus.req_ready}, 32'd1);
        tick();
        drive(2'b11, 2'b00, 2'b10, 32'h0, 32'hC, 32'h0);
        #1;
        chk("rr_after_idle_ready", {30'b0, bus.req_ready}, 32'd2);
        tick();

        // Port 1 alone, 8 back-to-back loads of words 4..11
        for (int i = 0; i < 8; i++) begin
            drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h10 + 32'(4 * i), 32'h0);
            #1;
            chk("single_ready", {30'b0, bus.req_ready}, 32'd2);
            tick();
            chk("single_resp_valid", {30'b0, bus.resp_valid}, 32'd2);
            chk("single_rdata1", bus.resp_rdata1, 32'(4 + i));
        end

        // Asynchronous reset in the middle of a granted store
        drive(2'b01, 2'b01, 2'b00, 32'h14, 32'h0, 32'h1234_5678);
        #1;
        chk("ar_we_before", {31'b0, mem_write_enable}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_we", {31'b0, mem_write_enable}, 32'd0);
        chk("ar_ready", {30'b0, bus.req_ready}, 32'd0);
        chk("ar_resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("ar_rdata0", bus.resp_rdata0, 32'd0);
        chk("ar_rdata1", bus.resp_rdata1, 32'd0);
        tick();
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        chk("ar_no_resp", {30'b0, bus.resp_valid}, 32'd0);
        chk("ar_mem_unchanged", mem[5], 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
